sd_block_server: RTL and testbench

- Responder side of the MiSTer-style SD block interface used by the floppy controllers.
- Services sd_rd/sd_wr requests from up to four drive initiators.
- Moves 512-byte blocks between a byte-wide backing memory (SDRAM/BRAM image store) and the initiators' sector buffers.
- Lets the core run with disk images preloaded in local memory, without the HPS.

---
 rtl/sd_block_server.sv | 181 ++++++++++++++++++
 tb/tb_sd_block_server.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_server.sv
// rtl/sd_block_server.sv - SD block responder moving 512-byte blocks between local memory and four drive buffers
module sd_block_server #(
    parameter int MEM_AW   = 22,
    parameter int LBA_BITS = 11,
    parameter int DIN_LAT  = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [3:0][31:0]        sd_lba,
    input  logic [3:0]              sd_rd,
    input  logic [3:0]              sd_wr,
    output logic [3:0]              sd_ack,
    output logic [8:0]              sd_buff_addr,
    output logic [7:0]              sd_buff_dout,
    input  logic [3:0][7:0]         sd_buff_din,
    output logic                    sd_buff_wr,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata,
    input  logic                    mem_ready,
    output logic                    busy
);

    localparam int LW = (DIN_LAT > 1) ? $clog2(DIN_LAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, GRANT, RD_MEM, RD_PUSH, WR_ADDR, WR_WAIT, WR_MEM, DONE
    } state_t;

    state_t                 state_q;
    logic [1:0]             ptr_q;
    logic [1:0]             pick_q;
    logic [1:0]             sel_q;
    logic [LBA_BITS-1:0]    lba_q;
    logic                   range_ok_q;
    logic [8:0]             i_q;
    logic [LW-1:0]          lat_q;
    logic [3:0]             ack_q;
    logic [8:0]             buff_addr_q;
    logic [7:0]             buff_dout_q;
    logic                   buff_wr_q;
    logic [MEM_AW-1:0]      mem_addr_q;
    logic                   mem_rd_q;
    logic                   mem_wr_q;
    logic [7:0]             mem_wdata_q;

    logic [3:0]             pend;
    logic [1:0]             pick_d;
    logic [MEM_AW-1:0]      xfer_addr;

    assign pend      = sd_rd | sd_wr;
    assign xfer_addr = MEM_AW'({sel_q, lba_q, i_q});

    // Scan downwards so the nearest pending drive at or after ptr wins.
    always_comb begin
        pick_d = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (pend[ptr_q + 2'(k)]) begin
                pick_d = ptr_q + 2'(k);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            pick_q      <= 2'd0;
            sel_q       <= 2'd0;
            lba_q       <= '0;
            range_ok_q  <= 1'b0;
            i_q         <= 9'd0;
            lat_q       <= '0;
            ack_q       <= 4'd0;
            buff_addr_q <= 9'd0;
            buff_dout_q <= 8'd0;
            buff_wr_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pend) begin
                        pick_q  <= pick_d;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    sel_q       <= pick_q;
                    lba_q       <= sd_lba[pick_q][LBA_BITS-1:0];
                    range_ok_q  <= (sd_lba[pick_q][31:LBA_BITS] == '0);
                    ack_q       <= 4'd1 << pick_q;
                    ptr_q       <= pick_q + 2'd1;
                    i_q         <= 9'd0;
                    buff_addr_q <= 9'd0;
                    state_q     <= sd_rd[pick_q] ? RD_MEM : WR_ADDR;
                end
                RD_MEM: begin
                    if (!range_ok_q) begin
                        buff_dout_q <= 8'd0;
                        buff_addr_q <= i_q;
                        buff_wr_q   <= 1'b1;
                        state_q     <= RD_PUSH;
                    end else if (!mem_rd_q) begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= xfer_addr;
                    end else if (mem_ready) begin
                        mem_rd_q    <= 1'b0;
                        buff_dout_q <= mem_rdata;
                        buff_addr_q <= i_q;
                        buff_wr_q   <= 1'b1;
                        state_q     <= RD_PUSH;
                    end
                end
                RD_PUSH: begin
                    buff_wr_q <= 1'b0;
                    if (i_q == 9'd511) begin
                        state_q <= DONE;
                    end else begin
                        i_q     <= i_q + 9'd1;
                        state_q <= RD_MEM;
                    end
                end
                WR_ADDR: begin
                    // sd_buff_addr already shows i; this is the first of DIN_LAT cycles.
                    if (DIN_LAT <= 1) begin
                        mem_wdata_q <= sd_buff_din[sel_q];
                        state_q     <= WR_MEM;
                    end else begin
                        lat_q   <= LW'(2);
                        state_q <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (lat_q == LW'(DIN_LAT)) begin
                        mem_wdata_q <= sd_buff_din[sel_q];
                        state_q     <= WR_MEM;
                    end else begin
                        lat_q <= lat_q + LW'(1);
                    end
                end
                WR_MEM: begin
                    if (range_ok_q && !mem_wr_q) begin
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= xfer_addr;
                    end else if (!range_ok_q || mem_ready) begin
                        mem_wr_q <= 1'b0;
                        if (i_q == 9'd511) begin
                            state_q <= DONE;
                        end else begin
                            i_q         <= i_q + 9'd1;
                            buff_addr_q <= i_q + 9'd1;
                            state_q     <= WR_ADDR;
                        end
                    end
                end
                DONE: begin
                    ack_q       <= 4'd0;
                    buff_addr_q <= 9'd0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = buff_addr_q;
    assign sd_buff_dout = buff_dout_q;
    assign sd_buff_wr   = buff_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sd_block_server.sv
// tb/tb_sd_block_server.sv - directed bench for sd_block_server with memory and initiator models
module tb_sd_block_server;
    localparam int MEM_AW = 22;

    logic                CLK = 1'b0;
    logic                RESET;
    logic [3:0][31:0]    sd_lba;
    logic [3:0]          sd_rd, sd_wr, sd_ack;
    logic [8:0]          sd_buff_addr;
    logic [7:0]          sd_buff_dout;
    logic [3:0][7:0]     sd_buff_din;
    logic                sd_buff_wr;
    logic [MEM_AW-1:0]   mem_addr;
    logic                mem_rd, mem_wr;
    logic [7:0]          mem_wdata, mem_rdata;
    logic                mem_ready, busy;

    sd_block_server #(.MEM_AW(22), .LBA_BITS(11), .DIN_LAT(2)) dut (
        .CLK(CLK), .RESET(RESET), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy)
    );

    always #5 CLK = ~CLK;

    bit [7:0]          mem [int];
    int                n_chk = 0, n_pass = 0;
    int                pulses, byte_idx, data_err, proto_err, rd_cycles, wr_cycles, ack_cycles;
    int                served[$];
    bit                prev_wr, active, rand_en, r0;
    logic [3:0]        prev_ack;
    logic [8:0]        prev_addr;
    logic [MEM_AW-1:0] a0;
    int                wait_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pat(input logic [31:0] a);
        return a[7:0] ^ {6'd0, a[9:8]};
    endfunction

    function automatic logic [31:0] baddr(input int d, input int lba, input int i);
        return {10'd0, 2'(d), 11'(lba), 9'(i)};
    endfunction

    function automatic int served_at(input int i);
        return (served.size() > i) ? served[i] : 99;
    endfunction

    task automatic clr();
        pulses = 0; data_err = 0; rd_cycles = 0; wr_cycles = 0; ack_cycles = 0;
        served.delete();
    endtask

    // One cycle: initiator buffer, drop-on-ack, monitors and a byte-wide memory with optional wait states.
    task automatic tick();
        int d, k;
        logic [7:0] expd;
        @(negedge CLK);
        for (int j = 0; j < 4; j++)
            sd_buff_din[j] = (j == 2) ? (8'hA5 ^ prev_addr[7:0]) : 8'hFF;
        prev_addr = sd_buff_addr;
        d = -1;
        for (int j = 0; j < 4; j++) begin
            if (sd_ack[j]) begin
                d = j; sd_rd[j] = 1'b0; sd_wr[j] = 1'b0;
                if (!prev_ack[j]) begin served.push_back(j); byte_idx = 0; end
            end
        end
        if ($countones(sd_ack) > 1) proto_err++;
        if (sd_ack != 0) ack_cycles++;
        prev_ack = sd_ack;
        if (sd_buff_wr) begin
            if (prev_wr || d < 0) proto_err++;
            else begin
                expd = (sd_lba[d] >= 2048) ? 8'h00 : pat(baddr(d, int'(sd_lba[d]), byte_idx));
                if (sd_buff_addr != 9'(byte_idx) || sd_buff_dout != expd) data_err++;
            end
            byte_idx++; pulses++;
        end
        prev_wr = sd_buff_wr;
        if (mem_rd) rd_cycles++;
        if (mem_wr) wr_cycles++;
        mem_ready = 1'b0;
        if (mem_rd && mem_wr) proto_err++;
        if (mem_rd || mem_wr) begin
            if (!active) begin
                active = 1; a0 = mem_addr; r0 = mem_rd;
                wait_left = rand_en ? int'($urandom_range(7, 0)) : 0;
            end else if (mem_addr != a0 || mem_rd != r0) proto_err++;
            if (wait_left == 0) begin
                mem_ready = 1'b1; active = 0; k = int'(mem_addr);
                if (mem_rd) mem_rdata = mem.exists(k) ? mem[k] : pat(32'(k));
                else mem[k] = mem_wdata;
            end else wait_left--;
        end else active = 0;
    endtask

    task automatic run_until(input int target, input int bound, input string tag);
        int n = 0;
        bit ok = 0;
        while (n < bound && !ok) begin
            tick(); n++;
            ok = (served.size() >= target) && !busy && sd_rd == 0 && sd_wr == 0;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_ctl"}, {sd_ack, sd_buff_wr, mem_rd, mem_wr, busy}, 32'd0);
        check({tag, "_maddr"}, 32'(mem_addr), 32'd0);
        check({tag, "_data"}, {sd_buff_addr, sd_buff_dout, mem_wdata}, 32'd0);
    endtask

    task automatic clear_models();
        active = 0; prev_wr = 0; prev_ack = 4'd0; mem_ready = 1'b0; byte_idx = 0;
    endtask

    task automatic check_wr_block(input int d, input int lba, input string tag);
        int werr = 0;
        int k;
        for (int i = 0; i < 512; i++) begin
            k = int'(baddr(d, lba, i));
            if (!mem.exists(k) || mem[k] != (8'hA5 ^ 8'(i))) werr++;
        end
        check(tag, 32'(werr), 32'd0);
    endtask

    initial begin
        RESET = 1'b1; sd_rd = 4'd0; sd_wr = 4'd0; sd_lba = '0; sd_buff_din = '0;
        mem_rdata = 8'd0; rand_en = 0; proto_err = 0; prev_addr = 9'd0;
        clear_models(); clr();
        #2 outs_zero("reset");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Zero-wait read, drive 0, LBA 5
        sd_lba[0] = 32'd5; sd_rd[0] = 1'b1;
        run_until(1, 4000, "rd0_done");
        check("rd0_served", 32'(served_at(0)), 32'd0);
        check("rd0_pulses", 32'(pulses), 32'd512);
        check("rd0_data", 32'(data_err), 32'd0);
        check("rd0_latency_ok", 32'(ack_cycles <= 1540), 32'd1);
        check("rd0_ack_low", 32'(sd_ack), 32'd0);

        // Zero-wait write, drive 2, LBA 17
        clr(); sd_lba[2] = 32'd17; sd_wr[2] = 1'b1;
        run_until(1, 6000, "wr2_done");
        check("wr2_no_buff_wr", 32'(pulses), 32'd0);
        check_wr_block(2, 17, "wr2_mem");

        // Round robin from reset
        RESET = 1'b1; @(negedge CLK); RESET = 1'b0; clear_models(); clr();
        sd_lba[1] = 32'd3; sd_lba[3] = 32'd40;
        sd_rd = 4'b1011;
        run_until(3, 12000, "arb_done");
        check("arb_first", 32'(served_at(0)), 32'd0);
        check("arb_second", 32'(served_at(1)), 32'd1);
        check("arb_third", 32'(served_at(2)), 32'd3);
        sd_rd = 4'b1001;
        run_until(5, 8000, "arb2_done");
        check("arb2_first", 32'(served_at(3)), 32'd0);
        check("arb2_second", 32'(served_at(4)), 32'd3);
        check("arb_data", 32'(data_err), 32'd0);

        // Out-of-range read and write on drive 1
        clr(); sd_lba[1] = 32'd2048; sd_rd[1] = 1'b1;
        run_until(1, 4000, "oor_rd_done");
        check("oor_rd_pulses", 32'(pulses), 32'd512);
        check("oor_rd_data", 32'(data_err), 32'd0);
        check("oor_rd_no_mem", 32'(rd_cycles), 32'd0);
        clr(); sd_lba[1] = 32'd4096; sd_wr[1] = 1'b1;
        run_until(1, 6000, "oor_wr_done");
        check("oor_wr_no_mem", 32'(wr_cycles), 32'd0);
        check("oor_wr_served", 32'(served_at(0)), 32'd1);

        // Random memory wait states
        rand_en = 1;
        clr(); sd_lba[0] = 32'd5; sd_rd[0] = 1'b1;
        run_until(1, 9000, "wait_rd_done");
        check("wait_rd_pulses", 32'(pulses), 32'd512);
        check("wait_rd_data", 32'(data_err), 32'd0);
        clr(); sd_lba[2] = 32'd300; sd_wr[2] = 1'b1;
        run_until(1, 10000, "wait_wr_done");
        check_wr_block(2, 300, "wait_wr_mem");
        rand_en = 0;

        // Read and write both requested: read wins
        clr(); sd_lba[3] = 32'd7; sd_rd[3] = 1'b1; sd_wr[3] = 1'b1;
        run_until(1, 4000, "conf_done");
        check("conf_pulses", 32'(pulses), 32'd512);
        check("conf_data", 32'(data_err), 32'd0);
        check("conf_no_wr", 32'(wr_cycles), 32'd0);

        // Reset in the middle of a read, then a fresh request
        clr(); sd_lba[0] = 32'd5; sd_rd[0] = 1'b1;
        for (int n = 0; n < 2000 && pulses < 201; n++) tick();
        check("mid_reached", 32'(pulses), 32'd201);
        RESET = 1'b1;
        #1 outs_zero("mid_rst");
        @(negedge CLK); RESET = 1'b0; clear_models();
        clr(); sd_lba[1] = 32'd9; sd_rd[1] = 1'b1;
        run_until(1, 4000, "post_rst_done");
        check("post_rst_pulses", 32'(pulses), 32'd512);
        check("post_rst_data", 32'(data_err), 32'd0);

        check("protocol", 32'(proto_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
